// File: rtl/program_loader.sv
// program_loader
//
// Purpose:
//   Upstream stage of the CPU. Receives a program image as a byte stream
//   (valid/ready), writes it into the CPU's 16x8 memory, holds the CPU
//   stalled while loading, then releases it with a one-cycle PC load of the
//   image's start address. Truncated streams are caught by an idle timeout.
//
// Stream format:
//   header byte : [7:4] start PC, [3:0] word count - 1 (1..16 words)
//   data bytes  : written to addresses 0, 1, ... in order
//   checksum    : only when LOADER_CHECKSUM_EN is defined; 8-bit sum of the
//                 header and all data bytes
//
// Configuration macro:
//   LOADER_CHECKSUM_EN - adds the CHECK state and the running-sum register.
//
// Parameters:
//   TIMEOUT_CYCLES - idle cycles tolerated between bytes during a load
//                    (0 disables the timeout)
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_data/in_valid        stream byte and its valid
//   in_ready                loader can accept a byte (decoded from state)
//   load_req                return from RUN/ERROR to IDLE
//   mem_address/data/write  memory write port, one strobe per data byte
//   cpu_run                 CPU may execute
//   pc_value/pc_load        start address and its one-cycle load pulse
//   loader_error            sticky error flag
//   words_loaded            data bytes written so far (0..16)

module program_loader #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       load_req,
  output logic [3:0] mem_address,
  output logic [7:0] mem_data,
  output logic       mem_write,
  output logic       cpu_run,
  output logic [3:0] pc_value,
  output logic       pc_load,
  output logic       loader_error,
  output logic [4:0] words_loaded
);

  // The idle counter only has to count up to TIMEOUT_CYCLES-1; the edge on
  // which it would reach TIMEOUT_CYCLES is the expiry edge itself.
  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_RUN,
    S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    count_q, count_d;
  logic [4:0]    words_loaded_q, words_loaded_d;
  logic [3:0]    mem_address_q, mem_address_d;
  logic [7:0]    mem_data_q, mem_data_d;
  logic          mem_write_q, mem_write_d;
  logic          cpu_run_q, cpu_run_d;
  logic [3:0]    pc_value_q, pc_value_d;
  logic          pc_load_q, pc_load_d;
  logic          loader_error_q, loader_error_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  logic accept;
  logic timeout_hit;
  logic last_word;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_LOAD)
`ifdef LOADER_CHECKSUM_EN
                    || (state_q == S_CHECK)
`endif
                    ;

  assign accept      = in_valid && in_ready;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (idle_cnt_q == TO_LAST);
  // words_loaded_q never exceeds count_q+1, so its low nibble is the next
  // write address and the address counter cannot wrap.
  assign last_word   = (words_loaded_q[3:0] == count_q);

  // Next-state and next-output logic. The idle counter defaults to zero, so
  // it is cleared by every accept and stays inactive outside LOAD/CHECK.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    words_loaded_d = words_loaded_q;
    mem_address_d  = mem_address_q;
    mem_data_d     = mem_data_q;
    mem_write_d    = 1'b0;
    pc_value_d     = pc_value_q;
    idle_cnt_d     = '0;
`ifdef LOADER_CHECKSUM_EN
    sum_d          = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          pc_value_d     = in_data[7:4];
          count_d        = in_data[3:0];
          words_loaded_d = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d          = in_data;
`endif
          state_d        = S_LOAD;
        end
      end

      S_LOAD: begin
        if (accept) begin
          mem_address_d  = words_loaded_q[3:0];
          mem_data_d     = in_data;
          mem_write_d    = 1'b1;
          words_loaded_d = words_loaded_q + 5'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d          = sum_q + in_data;
          if (last_word) state_d = S_CHECK;
`else
          if (last_word) state_d = S_DONE;
`endif
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end else if (TIMEOUT_CYCLES != 0) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          state_d = (in_data == sum_q) ? S_DONE : S_ERROR;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end else if (TIMEOUT_CYCLES != 0) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
`endif

      S_DONE: begin
        state_d = S_RUN;
      end

      S_RUN: begin
        if (load_req) state_d = S_IDLE;
      end

      S_ERROR: begin
        if (load_req) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state so they change
    // on the same edge as the state itself. DONE always leads into RUN, so
    // the PC load pulse coincides with the first RUN cycle.
    cpu_run_d      = (state_d == S_RUN);
    loader_error_d = (state_d == S_ERROR);
    pc_load_d      = (state_q == S_DONE);
  end

  // All state and registered outputs; reset also drops any write that was
  // pending from the previous accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      words_loaded_q <= '0;
      mem_address_q  <= '0;
      mem_data_q     <= '0;
      mem_write_q    <= 1'b0;
      cpu_run_q      <= 1'b0;
      pc_value_q     <= '0;
      pc_load_q      <= 1'b0;
      loader_error_q <= 1'b0;
      idle_cnt_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      words_loaded_q <= words_loaded_d;
      mem_address_q  <= mem_address_d;
      mem_data_q     <= mem_data_d;
      mem_write_q    <= mem_write_d;
      cpu_run_q      <= cpu_run_d;
      pc_value_q     <= pc_value_d;
      pc_load_q      <= pc_load_d;
      loader_error_q <= loader_error_d;
      idle_cnt_q     <= idle_cnt_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q          <= sum_d;
`endif
    end
  end

  assign mem_address  = mem_address_q;
  assign mem_data     = mem_data_q;
  assign mem_write    = mem_write_q;
  assign cpu_run      = cpu_run_q;
  assign pc_value     = pc_value_q;
  assign pc_load      = pc_load_q;
  assign loader_error = loader_error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//
// Purpose:
//   Scoreboard bench for program_loader. The stimulus side works out, from
//   the stream rules alone, which memory writes, PC loads and errors each
//   stream must produce (and on which cycle), and queues them. A monitor
//   sampling on the falling edge pops and compares whenever the DUT shows a
//   write, a PC load or a new error. Honours LOADER_CHECKSUM_EN.
//
// Ports: none (top-level bench).

module tb_program_loader;

  localparam int TO = 4;

  logic       clk;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       load_req;
  logic [3:0] mem_address;
  logic [7:0] mem_data;
  logic       mem_write;
  logic       cpu_run;
  logic [3:0] pc_value;
  logic       pc_load;
  logic       loader_error;
  logic [4:0] words_loaded;

  program_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .load_req     (load_req),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_write    (mem_write),
    .cpu_run      (cpu_run),
    .pc_value     (pc_value),
    .pc_load      (pc_load),
    .loader_error (loader_error),
    .words_loaded (words_loaded)
  );

  typedef struct {
    int         cyc;
    logic [3:0] addr;
    logic [7:0] data;
  } write_t;

  typedef struct {
    int         cyc;
    logic [3:0] pc;
    logic [4:0] words;
  } run_t;

  write_t wq[$];
  run_t   rq[$];
  int     eq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit prev_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: a byte accepted on edge N has its write visible while cyc==N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    checkOutput({tag, "_mem_address"}, 32'(mem_address), 32'd0);
    checkOutput({tag, "_mem_data"}, 32'(mem_data), 32'd0);
    checkOutput({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    checkOutput({tag, "_pc_value"}, 32'(pc_value), 32'd0);
    checkOutput({tag, "_pc_load"}, 32'(pc_load), 32'd0);
    checkOutput({tag, "_loader_error"}, 32'(loader_error), 32'd0);
    checkOutput({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  // Monitor: every observable event must match the head of its queue.
  always @(negedge clk) begin
    write_t w;
    run_t   r;
    int     e;
    if (!reset_n) begin
      prev_err = 1'b0;
    end else begin
      if (mem_write) begin
        if (wq.size() == 0) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL unexpected_write: got addr %0h data %0h at cycle %0d, required no write",
                   mem_address, mem_data, cyc);
        end else begin
          w = wq.pop_front();
          checkOutput("write_cycle", 32'(cyc), 32'(w.cyc));
          checkOutput("write_addr", 32'(mem_address), 32'(w.addr));
          checkOutput("write_data", 32'(mem_data), 32'(w.data));
        end
      end
      if (pc_load) begin
        if (rq.size() == 0) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL unexpected_pc_load: got pc_load=1 at cycle %0d, required 0", cyc);
        end else begin
          r = rq.pop_front();
          checkOutput("run_cycle", 32'(cyc), 32'(r.cyc));
          checkOutput("run_pc_value", 32'(pc_value), 32'(r.pc));
          checkOutput("run_cpu_run", 32'(cpu_run), 32'd1);
          checkOutput("run_words_loaded", 32'(words_loaded), 32'(r.words));
        end
      end
      if (loader_error && !prev_err) begin
        if (eq.size() == 0) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL unexpected_error: got loader_error=1 at cycle %0d, required 0", cyc);
        end else begin
          e = eq.pop_front();
          checkOutput("error_cycle", 32'(cyc), 32'(e));
          checkOutput("error_cpu_run", 32'(cpu_run), 32'd0);
          checkOutput("error_in_ready", 32'(in_ready), 32'd0);
        end
      end
      prev_err = loader_error;
    end
  end

  // Present one byte after 'gap' idle cycles; returns the cycle it was taken.
  task automatic sendByte(input logic [7:0] d, input int gap, output int acc_cyc);
    bit rdy;
    bit done;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    done     = 1'b0;
    acc_cyc  = -1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        done    = 1'b1;
        acc_cyc = cyc;
      end
    end
    in_valid = 1'b0;
    if (!done) checkOutput("handshake_timeout", 32'd0, 32'd1);
  endtask

  // Wait (bounded) for all queued expectations to be consumed.
  task automatic waitEvents(input int bound);
    for (int k = 0; k < bound; k++) begin
      if (wq.size() == 0 && rq.size() == 0 && eq.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("events_drained", 32'(wq.size() + rq.size() + eq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Reference model of a whole stream: expected PC, word count and checksum
  // come straight from the header and data bytes.
  task automatic applyStimulus(input logic [7:0] hdr, input logic [7:0] dat[16],
                               input bit corrupt, input int maxgap, input int lastgap,
                               input bit noise);
    int         n;
    int         acc;
    int         last;
    logic [7:0] sum;
    write_t     w;
    run_t       r;
    bit         ok;
    n   = int'(hdr[3:0]) + 1;
    sum = hdr;
    ok  = 1'b1;
    sendByte(hdr, $urandom_range(0, maxgap), acc);
    for (int i = 0; i < n; i++) begin
      load_req = (noise && i != n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      sendByte(dat[i], (i == n - 1 && lastgap >= 0) ? lastgap : $urandom_range(0, maxgap), acc);
      w.cyc = acc; w.addr = 4'(i); w.data = dat[i];
      wq.push_back(w);
      sum = sum + dat[i];
    end
    load_req = 1'b0;
    last = acc;
`ifdef LOADER_CHECKSUM_EN
    sendByte(corrupt ? (sum ^ 8'h01) : sum, $urandom_range(0, maxgap), acc);
    last = acc;
    ok   = !corrupt;
`else
    if (corrupt) ok = 1'b1;
`endif
    if (ok) begin
      r.cyc = last + 1; r.pc = hdr[7:4]; r.words = 5'(n);
      rq.push_back(r);
    end else begin
      eq.push_back(last);
    end
    waitEvents(40);
  endtask

  task automatic returnToIdle();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    checkOutput("idle_cpu_run", 32'(cpu_run), 32'd0);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_loader_error", 32'(loader_error), 32'd0);
  endtask

  initial begin
    logic [7:0] dat[16];
    int         acc;
    write_t     w;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    load_req = 1'b0;
    #2;
    checkResetValues("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Three words back to back, then probe RUN with a byte that must not be taken.
    $display("[TB] basic three-word load");
    dat[0] = 8'hA1; dat[1] = 8'hB2; dat[2] = 8'hC3;
    applyStimulus(8'h32, dat, 1'b0, 0, -1, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      checkOutput("run_in_ready", 32'(in_ready), 32'd0);
      checkOutput("run_hold_cpu_run", 32'(cpu_run), 32'd1);
    end
    checkOutput("run_words_held", 32'(words_loaded), 32'd3);
    checkOutput("run_pc_held", 32'(pc_value), 32'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    returnToIdle();

    // Full 16-word image with random gaps and ignored load_req noise.
    $display("[TB] sixteen-word load with gaps");
    for (int i = 0; i < 16; i++) dat[i] = 8'(i);
    applyStimulus(8'h0F, dat, 1'b0, 2, -1, 1'b1);
    returnToIdle();

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] checksum good and bad");
    dat[0] = 8'h10;
    applyStimulus(8'h50, dat, 1'b0, 1, -1, 1'b0);
    returnToIdle();
    applyStimulus(8'h50, dat, 1'b1, 1, -1, 1'b0);
    checkOutput("cks_err_flag", 32'(loader_error), 32'd1);
    checkOutput("cks_err_cpu_run", 32'(cpu_run), 32'd0);
    returnToIdle();
`endif

    // Truncated stream: error exactly TO cycles after the last accept.
    $display("[TB] timeout");
    sendByte(8'h01, 0, acc);
    sendByte(8'h5A, 0, acc);
    w.cyc = acc; w.addr = 4'h0; w.data = 8'h5A;
    wq.push_back(w);
    eq.push_back(acc + TO);
    waitEvents(20);
    checkOutput("timeout_err_flag", 32'(loader_error), 32'd1);
    returnToIdle();

    // A byte landing on the expiry edge is accepted instead.
    dat[0] = 8'h11; dat[1] = 8'h22;
    applyStimulus(8'h01, dat, 1'b0, 0, TO - 1, 1'b0);
    returnToIdle();

    // Reset mid-load after two of four data bytes: pending write is dropped.
    $display("[TB] reset mid-load");
    sendByte(8'h93, 0, acc);
    sendByte(8'h44, 0, acc);
    w.cyc = acc; w.addr = 4'h0; w.data = 8'h44;
    wq.push_back(w);
    sendByte(8'h55, 0, acc);
    reset_n = 1'b0;
    wq.delete(); rq.delete(); eq.delete();
    #1;
    checkResetValues("midreset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    dat[0] = 8'h66; dat[1] = 8'h77;
    applyStimulus(8'hE1, dat, 1'b0, 1, -1, 1'b0);
    returnToIdle();

    // Randomised streams.
    $display("[TB] random streams");
    for (int t = 0; t < 8; t++) begin
      bit corrupt;
      for (int i = 0; i < 16; i++) dat[i] = 8'($urandom);
      corrupt = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      corrupt = ($urandom_range(0, 3) == 0);
`endif
      applyStimulus(8'($urandom), dat, corrupt, 2, -1, 1'($urandom_range(0, 1)));
      returnToIdle();
    end

    repeat (3) @(posedge clk);
    checkOutput("final_queues_empty", 32'(wq.size() + rq.size() + eq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got still running, required finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
